// File: rtl/axi_slave_mem_if.sv
// AXI3-style bus bundle for axi_slave_mem.
// Carries the AW, W, B, AR and R channels; clock and reset stay outside.
//   master: drives requests (valid/payload), receives ready/responses
//   slave : receives requests, drives ready/responses
interface axi_slave_mem_if #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
);
    logic [3:0]              awid;
    logic [ADDR_WIDTH-1:0]   awaddr;
    logic [3:0]              awlen;
    logic [2:0]              awsize;
    logic [1:0]              awburst;
    logic [1:0]              awlock;
    logic [1:0]              awcache;
    logic [1:0]              awprot;
    logic                    awvalid;
    logic                    awready;

    logic [3:0]              wid;
    logic [DATA_WIDTH-1:0]   wdata;
    logic [DATA_WIDTH/8-1:0] wstrb;
    logic                    wlast;
    logic                    wvalid;
    logic                    wready;

    logic [3:0]              bid;
    logic [1:0]              bresp;
    logic                    bvalid;
    logic                    bready;

    logic [3:0]              arid;
    logic [ADDR_WIDTH-1:0]   araddr;
    logic [3:0]              arlen;
    logic [2:0]              arsize;
    logic [1:0]              arburst;
    logic [1:0]              arlock;
    logic [1:0]              arcache;
    logic [1:0]              arprot;
    logic                    arvalid;
    logic                    arready;

    logic [3:0]              rid;
    logic [DATA_WIDTH-1:0]   rdata;
    logic [1:0]              rresp;
    logic                    rlast;
    logic                    rvalid;
    logic                    rready;

    modport master (
        output awid, awaddr, awlen, awsize, awburst,
        output awlock, awcache, awprot, awvalid,
        input  awready,
        output wid, wdata, wstrb, wlast, wvalid,
        input  wready,
        input  bid, bresp, bvalid,
        output bready,
        output arid, araddr, arlen, arsize, arburst,
        output arlock, arcache, arprot, arvalid,
        input  arready,
        input  rid, rdata, rresp, rlast, rvalid,
        output rready
    );

    modport slave (
        input  awid, awaddr, awlen, awsize, awburst,
        input  awlock, awcache, awprot, awvalid,
        output awready,
        input  wid, wdata, wstrb, wlast, wvalid,
        output wready,
        output bid, bresp, bvalid,
        input  bready,
        input  arid, araddr, arlen, arsize, arburst,
        input  arlock, arcache, arprot, arvalid,
        output arready,
        output rid, rdata, rresp, rlast, rvalid,
        input  rready
    );
endinterface

// File: rtl/axi_slave_mem.sv
// AXI slave backed by a register-array memory with independent
// read and write burst engines (FIXED / INCR / WRAP).
// Ports:
//   aclk - clock, all state on posedge
//   arst - asynchronous active-low reset, also clears the memory
//   bus  - axi_slave_mem_if.slave (AW, W, B, AR, R channels)
module axi_slave_mem #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    parameter int MEM_DEPTH  = 256
) (
    input logic            aclk,
    input logic            arst,
    axi_slave_mem_if.slave bus
);
    localparam int BYTES = DATA_WIDTH / 8;
    localparam int LSB   = $clog2(BYTES);
    localparam int IDX_W = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1;
    localparam int AW1   = ADDR_WIDTH + 1;
    localparam logic [AW1-1:0] LIMIT = AW1'(MEM_DEPTH * BYTES);

    typedef logic [ADDR_WIDTH-1:0] addr_t;

    function automatic addr_t next_addr(
        input addr_t      a,
        input logic [2:0] size,
        input logic [3:0] len,
        input logic [1:0] burst
    );
        addr_t inc;
        addr_t mask;
        inc  = ADDR_WIDTH'(1) << size;
        mask = (ADDR_WIDTH'({1'b0, len} + 5'd1) << size) - ADDR_WIDTH'(1);
        case (burst)
            2'b01:   next_addr = a + inc;
            // WRAP keeps the upper bits of the aligned block fixed.
            2'b10:   next_addr = (a & ~mask) | ((a + inc) & mask);
            default: next_addr = a;
        endcase
    endfunction

    function automatic logic cfg_err(
        input logic [2:0] size,
        input logic [3:0] len,
        input logic [1:0] burst
    );
        logic bad_wrap;
        bad_wrap = (burst == 2'b10) &&
                   !(len == 4'd1 || len == 4'd3 ||
                     len == 4'd7 || len == 4'd15);
        cfg_err = (burst == 2'b11) || (int'(size) > LSB) || bad_wrap;
    endfunction

    function automatic logic oor(input addr_t a);
        oor = {1'b0, a} >= LIMIT;
    endfunction

    logic [DATA_WIDTH-1:0] mem [MEM_DEPTH];

    // Ready outputs stay low until the first edge after reset release.
    logic up;

    always_ff @(posedge aclk or negedge arst) begin
        if (!arst) up <= 1'b0;
        else       up <= 1'b1;
    end

    logic unused_ok;
    assign unused_ok = ^{bus.awlock, bus.awcache, bus.awprot,
                         bus.arlock, bus.arcache, bus.arprot};

    // ---------------- write side ----------------
    typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} w_state_t;
    w_state_t w_state, w_next;

    logic [3:0]  w_id, w_len, w_cnt;
    addr_t       w_addr;
    logic [2:0]  w_size;
    logic [1:0]  w_burst;
    logic        w_err;
    logic [3:0]  b_id;
    logic [1:0]  b_resp;
    logic        aw_hs, w_hs, w_final, w_beat_err;
    logic [IDX_W-1:0] w_idx;

    assign aw_hs   = bus.awvalid && bus.awready;
    assign w_hs    = bus.wvalid && bus.wready;
    assign w_final = (w_cnt == w_len);
    assign w_idx   = w_addr[LSB +: IDX_W];
    assign w_beat_err = (bus.wlast != w_final) ||
                        (bus.wid != w_id) || oor(w_addr);

    always_ff @(posedge aclk or negedge arst) begin
        if (!arst) w_state <= W_IDLE;
        else       w_state <= w_next;
    end

    always_comb begin
        w_next      = w_state;
        bus.awready = 1'b0;
        bus.wready  = 1'b0;
        bus.bvalid  = 1'b0;
        case (w_state)
            W_IDLE: begin
                bus.awready = up;
                if (up && bus.awvalid) w_next = W_DATA;
            end
            W_DATA: begin
                bus.wready = 1'b1;
                // wlast is only checked, never used to end the burst.
                if (bus.wvalid && w_final) w_next = W_RESP;
            end
            W_RESP: begin
                bus.bvalid = 1'b1;
                if (bus.bready) w_next = W_IDLE;
            end
            default: w_next = W_IDLE;
        endcase
    end

    always_ff @(posedge aclk or negedge arst) begin
        if (!arst) begin
            w_id    <= '0;
            w_addr  <= '0;
            w_len   <= '0;
            w_size  <= '0;
            w_burst <= '0;
            w_cnt   <= '0;
            w_err   <= 1'b0;
            b_id    <= '0;
            b_resp  <= '0;
        end else if (aw_hs) begin
            w_id    <= bus.awid;
            w_addr  <= bus.awaddr;
            w_len   <= bus.awlen;
            w_size  <= bus.awsize;
            w_burst <= bus.awburst;
            w_cnt   <= '0;
            w_err   <= cfg_err(bus.awsize, bus.awlen, bus.awburst);
        end else if (w_hs) begin
            w_addr <= next_addr(w_addr, w_size, w_len, w_burst);
            w_cnt  <= w_cnt + 4'd1;
            w_err  <= w_err | w_beat_err;
            if (w_final) begin
                b_id   <= w_id;
                b_resp <= (w_err || w_beat_err) ? 2'b10 : 2'b00;
            end
        end
    end

    assign bus.bid   = b_id;
    assign bus.bresp = b_resp;

    always_ff @(posedge aclk or negedge arst) begin
        if (!arst) begin
            for (int i = 0; i < MEM_DEPTH; i++) mem[i] <= '0;
        end else if (w_hs && !oor(w_addr)) begin
            for (int b = 0; b < BYTES; b++)
                if (bus.wstrb[b])
                    mem[w_idx][b*8 +: 8] <= bus.wdata[b*8 +: 8];
        end
    end

    // ---------------- read side ----------------
    typedef enum logic {R_IDLE, R_DATA} r_state_t;
    r_state_t r_state, r_next;

    logic [3:0]  r_id, r_len, r_cnt;
    addr_t       r_addr;
    logic [2:0]  r_size;
    logic [1:0]  r_burst;
    logic        r_cfg_err;
    logic        ar_hs, r_hs, r_final, r_act;
    logic [IDX_W-1:0] r_idx;

    assign ar_hs   = bus.arvalid && bus.arready;
    assign r_hs    = bus.rvalid && bus.rready;
    assign r_final = (r_cnt == r_len);
    assign r_act   = (r_state == R_DATA);
    assign r_idx   = r_addr[LSB +: IDX_W];

    always_ff @(posedge aclk or negedge arst) begin
        if (!arst) r_state <= R_IDLE;
        else       r_state <= r_next;
    end

    always_comb begin
        r_next      = r_state;
        bus.arready = 1'b0;
        bus.rvalid  = 1'b0;
        case (r_state)
            R_IDLE: begin
                bus.arready = up;
                if (up && bus.arvalid) r_next = R_DATA;
            end
            R_DATA: begin
                bus.rvalid = 1'b1;
                if (bus.rready && r_final) r_next = R_IDLE;
            end
            default: r_next = R_IDLE;
        endcase
    end

    always_ff @(posedge aclk or negedge arst) begin
        if (!arst) begin
            r_id      <= '0;
            r_addr    <= '0;
            r_len     <= '0;
            r_size    <= '0;
            r_burst   <= '0;
            r_cnt     <= '0;
            r_cfg_err <= 1'b0;
        end else if (ar_hs) begin
            r_id      <= bus.arid;
            r_addr    <= bus.araddr;
            r_len     <= bus.arlen;
            r_size    <= bus.arsize;
            r_burst   <= bus.arburst;
            r_cnt     <= '0;
            r_cfg_err <= cfg_err(bus.arsize, bus.arlen, bus.arburst);
        end else if (r_hs) begin
            r_addr <= next_addr(r_addr, r_size, r_len, r_burst);
            r_cnt  <= r_cnt + 4'd1;
        end
    end

    // Read data is taken straight from the array so a write lands
    // on rdata the cycle after it is committed.
    assign bus.rid   = r_id;
    assign bus.rlast = r_act && r_final;
    assign bus.rresp = (r_act && (r_cfg_err || oor(r_addr))) ?
                       2'b10 : 2'b00;
    assign bus.rdata = (r_act && !oor(r_addr)) ? mem[r_idx] : '0;

endmodule

// File: tb/tb_axi_slave_mem.sv
// Self-checking bench for axi_slave_mem: directed table, corner
// sequences and randomized bursts against a byte-array model.
module tb_axi_slave_mem;
    localparam int BUD = 40;
    localparam int MEMB = 1024;

    logic aclk;
    logic arst;

    axi_slave_mem_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) bus ();

    axi_slave_mem #(
        .ADDR_WIDTH(32),
        .DATA_WIDTH(32),
        .MEM_DEPTH (256)
    ) dut (
        .aclk(aclk),
        .arst(arst),
        .bus (bus)
    );

    initial aclk = 1'b0;
    always #5 aclk = ~aclk;

    int cmp_n;
    int bad_n;

    logic [7:0]  mb   [MEMB];
    logic [31:0] wdat [16];
    logic [3:0]  wstb [16];
    logic [31:0] rdat [16];
    logic [1:0]  rrsp [16];
    logic        rlst [16];
    logic [3:0]  rids [16];

    typedef struct {
        bit          pre_en;
        int          pre_addr;
        logic [31:0] pre;
        int          wr_addr;
        logic [31:0] data;
        logic [3:0]  strb;
        int          rd_addr;
        logic [1:0]  exp_b;
        logic [31:0] exp_r;
        logic [1:0]  exp_rr;
    } vec_t;

    vec_t tbl [8];

    task automatic tick();
        @(posedge aclk);
        #1;
    endtask

    task automatic chk(input string nm, input logic [63:0] got,
                       input logic [63:0] exp);
        cmp_n++;
        if (got !== exp) begin
            bad_n++;
            $display("FAIL %s: got %h want %h", nm, got, exp);
        end
    endtask

    task automatic tmo(input string nm);
        cmp_n++;
        bad_n++;
        $display("FAIL %s: timeout, got no handshake want one", nm);
    endtask

    // ---- reference model: address list from the burst rules ----
    function automatic int beat_addr(input int a, input int size,
                                     input int len, input int burst,
                                     input int k);
        int inc;
        int blk;
        int base;
        inc = 1 << size;
        blk = (len + 1) * inc;
        if (burst == 1) return a + k * inc;
        if (burst == 2) begin
            base = a - (a % blk);
            return base + ((a - base) + k * inc) % blk;
        end
        return a;
    endfunction

    function automatic bit cfg_bad(input int size, input int len,
                                   input int burst);
        bit wrap_bad;
        wrap_bad = (burst == 2) && !(len == 1 || len == 3 ||
                                     len == 7 || len == 15);
        return (burst == 3) || (size > 2) || wrap_bad;
    endfunction

    function automatic logic [1:0] exp_wresp(input int a, input int size,
                                             input int len, input int burst,
                                             input bit bad_wid,
                                             input int early);
        bit e;
        e = cfg_bad(size, len, burst) || bad_wid || (early >= 0);
        for (int k = 0; k <= len; k++)
            if (beat_addr(a, size, len, burst, k) >= MEMB) e = 1'b1;
        return e ? 2'b10 : 2'b00;
    endfunction

    function automatic logic [31:0] mword(input int a);
        int w;
        if (a >= MEMB || a < 0) return 32'h0;
        w = a & ~3;
        return {mb[w+3], mb[w+2], mb[w+1], mb[w]};
    endfunction

    task automatic model_clear();
        for (int i = 0; i < MEMB; i++) mb[i] = 8'h0;
    endtask

    // ---- bus tasks ----
    task automatic axi_write(input logic [3:0] id, input int addr,
                             input int len, input int size,
                             input int burst, input bit bad_wid,
                             input int early, input int bdelay,
                             output logic [3:0] got_id,
                             output logic [1:0] got_resp);
        int n;
        int ba;
        got_id   = 'x;
        got_resp = 'x;
        bus.awid    = id;
        bus.awaddr  = addr;
        bus.awlen   = 4'(len);
        bus.awsize  = 3'(size);
        bus.awburst = 2'(burst);
        bus.awlock  = 2'($urandom);
        bus.awcache = 2'($urandom);
        bus.awprot  = 2'($urandom);
        bus.awvalid = 1'b1;
        n = 0;
        while (!bus.awready && n < BUD) begin tick(); n++; end
        if (!bus.awready) begin
            bus.awvalid = 1'b0;
            tmo("aw_ready");
            return;
        end
        tick();
        bus.awvalid = 1'b0;
        for (int k = 0; k <= len; k++) begin
            if ($urandom_range(0, 3) == 0) tick();
            bus.wid    = bad_wid ? (id ^ 4'h5) : id;
            bus.wdata  = wdat[k];
            bus.wstrb  = wstb[k];
            bus.wlast  = (k == len) || (k == early);
            bus.wvalid = 1'b1;
            n = 0;
            while (!bus.wready && n < BUD) begin tick(); n++; end
            if (!bus.wready) begin
                bus.wvalid = 1'b0;
                tmo("w_ready");
                return;
            end
            tick();
            bus.wvalid = 1'b0;
        end
        n = 0;
        while (!bus.bvalid && n < BUD) begin tick(); n++; end
        if (!bus.bvalid) begin
            tmo("b_valid");
            return;
        end
        got_id   = bus.bid;
        got_resp = bus.bresp;
        for (int i = 0; i < bdelay; i++) begin
            tick();
            chk("b_hold_bvalid", 64'(bus.bvalid), 64'(1));
            chk("b_hold_bid", 64'(bus.bid), 64'(got_id));
            chk("b_hold_bresp", 64'(bus.bresp), 64'(got_resp));
            chk("b_hold_awready", 64'(bus.awready), 64'(0));
        end
        bus.bready = 1'b1;
        tick();
        bus.bready = 1'b0;
        chk("b_done_bvalid", 64'(bus.bvalid), 64'(0));
        chk("b_done_awready", 64'(bus.awready), 64'(1));
        for (int k = 0; k <= len; k++) begin
            ba = beat_addr(addr, size, len, burst, k);
            if (ba < MEMB)
                for (int b = 0; b < 4; b++)
                    if (wstb[k][b]) mb[(ba & ~3) + b] = wdat[k][8*b +: 8];
        end
    endtask

    task automatic axi_read(input logic [3:0] id, input int addr,
                            input int len, input int size,
                            input int burst, output bit ok);
        int n;
        bit held;
        logic [38:0] prev;
        ok = 1'b0;
        prev = '0;
        bus.arid    = id;
        bus.araddr  = addr;
        bus.arlen   = 4'(len);
        bus.arsize  = 3'(size);
        bus.arburst = 2'(burst);
        bus.arlock  = 2'($urandom);
        bus.arcache = 2'($urandom);
        bus.arprot  = 2'($urandom);
        bus.arvalid = 1'b1;
        n = 0;
        while (!bus.arready && n < BUD) begin tick(); n++; end
        if (!bus.arready) begin
            bus.arvalid = 1'b0;
            tmo("ar_ready");
            return;
        end
        tick();
        bus.arvalid = 1'b0;
        for (int k = 0; k <= len; k++) begin
            held = 1'b0;
            for (int c = 0; c < 8; c++) begin
                if (!bus.rvalid) begin
                    bus.rready = 1'b0;
                    tmo("r_valid");
                    return;
                end
                if (held)
                    chk("r_stable", 64'({bus.rid, bus.rdata,
                                         bus.rresp, bus.rlast}),
                        64'(prev));
                prev = {bus.rid, bus.rdata, bus.rresp, bus.rlast};
                bus.rready = (c >= 3) || ($urandom_range(0, 2) != 0);
                if (bus.rready) begin
                    rdat[k] = bus.rdata;
                    rrsp[k] = bus.rresp;
                    rlst[k] = bus.rlast;
                    rids[k] = bus.rid;
                    tick();
                    break;
                end
                held = 1'b1;
                tick();
            end
        end
        bus.rready = 1'b0;
        chk("r_done_rvalid", 64'(bus.rvalid), 64'(0));
        chk("r_done_arready", 64'(bus.arready), 64'(1));
        ok = 1'b1;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got no finish want finish");
        $fatal(1);
    end

    initial begin
        logic [3:0]  gid;
        logic [1:0]  gresp;
        bit          ok;
        int          n;
        int          a, ln, sz, bu, ea, ba;
        bit          bw;
        logic [3:0]  id;

        cmp_n = 0;
        bad_n = 0;
        model_clear();
        bus.awid = '0; bus.awaddr = '0; bus.awlen = '0;
        bus.awsize = '0; bus.awburst = '0; bus.awlock = '0;
        bus.awcache = '0; bus.awprot = '0; bus.awvalid = 1'b0;
        bus.wid = '0; bus.wdata = '0; bus.wstrb = '0;
        bus.wlast = 1'b0; bus.wvalid = 1'b0; bus.bready = 1'b0;
        bus.arid = '0; bus.araddr = '0; bus.arlen = '0;
        bus.arsize = '0; bus.arburst = '0; bus.arlock = '0;
        bus.arcache = '0; bus.arprot = '0; bus.arvalid = 1'b0;
        bus.rready = 1'b0;

        // reset state
        arst = 1'b1;
        #1 arst = 1'b0;
        #2;
        chk("rst_awready", 64'(bus.awready), 64'(0));
        chk("rst_wready", 64'(bus.wready), 64'(0));
        chk("rst_bvalid", 64'(bus.bvalid), 64'(0));
        chk("rst_arready", 64'(bus.arready), 64'(0));
        chk("rst_rvalid", 64'(bus.rvalid), 64'(0));
        chk("rst_rlast", 64'(bus.rlast), 64'(0));
        chk("rst_bid_bresp", 64'({bus.bid, bus.bresp}), 64'(0));
        chk("rst_rid_rresp", 64'({bus.rid, bus.rresp}), 64'(0));
        chk("rst_rdata", 64'(bus.rdata), 64'(0));
        repeat (3) @(posedge aclk);
        @(negedge aclk);
        arst = 1'b1;
        tick();
        chk("rel_awready", 64'(bus.awready), 64'(1));
        chk("rel_arready", 64'(bus.arready), 64'(1));

        // INCR write then read back
        for (int k = 0; k < 4; k++) begin
            wdat[k] = 32'(k + 1);
            wstb[k] = 4'hF;
        end
        axi_write(4'd3, 'h10, 3, 2, 1, 1'b0, -1, 0, gid, gresp);
        chk("incr_bid", 64'(gid), 64'(3));
        chk("incr_bresp", 64'(gresp), 64'(0));
        axi_read(4'd5, 'h10, 3, 2, 1, ok);
        if (ok)
            for (int k = 0; k < 4; k++) begin
                chk("incr_rdata", 64'(rdat[k]), 64'(k + 1));
                chk("incr_rlast", 64'(rlst[k]), 64'(k == 3));
                chk("incr_rresp", 64'(rrsp[k]), 64'(0));
                chk("incr_rid", 64'(rids[k]), 64'(5));
            end

        // WRAP write from 0x18: lands at 18,1C,10,14
        for (int k = 0; k < 4; k++) wdat[k] = 32'hA0 + 32'(k);
        axi_write(4'd9, 'h18, 3, 2, 2, 1'b0, -1, 0, gid, gresp);
        chk("wrap_bresp", 64'(gresp), 64'(0));
        axi_read(4'd1, 'h10, 3, 2, 1, ok);
        if (ok) begin
            chk("wrap_lay0", 64'(rdat[0]), 64'('hA2));
            chk("wrap_lay1", 64'(rdat[1]), 64'('hA3));
            chk("wrap_lay2", 64'(rdat[2]), 64'('hA0));
            chk("wrap_lay3", 64'(rdat[3]), 64'('hA1));
        end
        axi_read(4'd2, 'h18, 3, 2, 2, ok);
        if (ok)
            for (int k = 0; k < 4; k++)
                chk("wrap_rd", 64'(rdat[k]), 64'('hA0 + k));

        // early wlast and wid mismatch still take 4 beats, SLVERR
        axi_write(4'd4, 'h80, 3, 2, 1, 1'b0, 2, 0, gid, gresp);
        chk("early_last_bresp", 64'(gresp), 64'(2));
        chk("early_last_bid", 64'(gid), 64'(4));
        axi_write(4'd6, 'h90, 3, 2, 1, 1'b1, -1, 0, gid, gresp);
        chk("bad_wid_bresp", 64'(gresp), 64'(2));

        // bready held low
        axi_write(4'd12, 'hA0, 0, 2, 1, 1'b0, -1, 5, gid, gresp);
        chk("bhold_bid", 64'(gid), 64'(12));
        chk("bhold_bresp", 64'(gresp), 64'(0));

        // single-beat table
        tbl[0] = '{1, 'h20, 32'hAABBCCDD, 'h20, 32'h11223344, 4'b0101,
                   'h20, 2'b00, 32'hAA22CC44, 2'b00};
        tbl[1] = '{1, 'h24, 32'h12345678, 'h24, 32'hFFFFFFFF, 4'b1000,
                   'h24, 2'b00, 32'hFF345678, 2'b00};
        tbl[2] = '{1, 'h28, 32'hCAFEF00D, 'h28, 32'h00000000, 4'b0000,
                   'h28, 2'b00, 32'hCAFEF00D, 2'b00};
        tbl[3] = '{1, 'h3FC, 32'h0, 'h3FC, 32'h87654321, 4'b1111,
                   'h3FC, 2'b00, 32'h87654321, 2'b00};
        tbl[4] = '{1, 'h000, 32'h5A5A5A5A, 'h400, 32'hDEADBEEF, 4'b1111,
                   'h000, 2'b10, 32'h5A5A5A5A, 2'b00};
        tbl[5] = '{0, 0, 32'h0, 'h400, 32'h01020304, 4'b1111,
                   'h400, 2'b10, 32'h0, 2'b10};
        tbl[6] = '{1, 'h2C, 32'h0, 'h2C, 32'h1234BEEF, 4'b0011,
                   'h2C, 2'b00, 32'h0000BEEF, 2'b00};
        tbl[7] = '{0, 0, 32'h0, 'h7FC, 32'hFFFFFFFF, 4'b1111,
                   'h3FC, 2'b10, 32'h87654321, 2'b00};
        for (int i = 0; i < 8; i++) begin
            if (tbl[i].pre_en) begin
                wdat[0] = tbl[i].pre;
                wstb[0] = 4'hF;
                axi_write(4'(i), tbl[i].pre_addr, 0, 2, 1, 1'b0, -1, 0,
                          gid, gresp);
            end
            wdat[0] = tbl[i].data;
            wstb[0] = tbl[i].strb;
            axi_write(4'(i), tbl[i].wr_addr, 0, 2, 1, 1'b0, -1, 0,
                      gid, gresp);
            chk($sformatf("tbl%0d_bresp", i), 64'(gresp),
                64'(tbl[i].exp_b));
            axi_read(4'(i), tbl[i].rd_addr, 0, 2, 1, ok);
            if (ok) begin
                chk($sformatf("tbl%0d_rdata", i), 64'(rdat[0]),
                    64'(tbl[i].exp_r));
                chk($sformatf("tbl%0d_rresp", i), 64'(rrsp[0]),
                    64'(tbl[i].exp_rr));
            end
        end

        // randomized bursts against the model
        for (int t = 0; t < 60; t++) begin
            a  = int'($urandom_range(0, 'h13F)) * 4;
            bu = int'($urandom_range(0, 3));
            sz = int'($urandom_range(0, 3));
            if (bu == 2) ln = (2 << $urandom_range(0, 3)) - 1;
            else         ln = int'($urandom_range(0, 15));
            id = 4'($urandom);
            if ($urandom_range(0, 1) == 0) begin
                for (int k = 0; k < 16; k++) begin
                    wdat[k] = $urandom;
                    wstb[k] = 4'($urandom);
                end
                bw = ($urandom_range(0, 7) == 0);
                ea = (ln > 0 && $urandom_range(0, 7) == 0) ?
                     int'($urandom_range(0, ln - 1)) : -1;
                axi_write(id, a, ln, sz, bu, bw, ea,
                          int'($urandom_range(0, 2)), gid, gresp);
                chk("rnd_bid", 64'(gid), 64'(id));
                chk("rnd_bresp", 64'(gresp),
                    64'(exp_wresp(a, sz, ln, bu, bw, ea)));
            end else begin
                axi_read(id, a, ln, sz, bu, ok);
                if (ok)
                    for (int k = 0; k <= ln; k++) begin
                        ba = beat_addr(a, sz, ln, bu, k);
                        chk("rnd_rdata", 64'(rdat[k]), 64'(mword(ba)));
                        chk("rnd_rresp", 64'(rrsp[k]),
                            64'((cfg_bad(sz, ln, bu) || ba >= MEMB) ?
                                2 : 0));
                        chk("rnd_rlast", 64'(rlst[k]), 64'(k == ln));
                        chk("rnd_rid", 64'(rids[k]), 64'(id));
                    end
            end
        end

        // reset in the middle of a read burst
        for (int k = 0; k < 4; k++) begin
            wdat[k] = 32'h11110000 + 32'(k);
            wstb[k] = 4'hF;
        end
        axi_write(4'd1, 'h40, 3, 2, 1, 1'b0, -1, 0, gid, gresp);
        bus.arid = 4'd6; bus.araddr = 'h40; bus.arlen = 4'd3;
        bus.arsize = 3'd2; bus.arburst = 2'd1; bus.arvalid = 1'b1;
        n = 0;
        while (!bus.arready && n < BUD) begin tick(); n++; end
        if (!bus.arready) tmo("mid_rst_ar");
        tick();
        bus.arvalid = 1'b0;
        bus.rready = 1'b1;
        tick();
        tick();
        chk("mid_rst_beat2", 64'(bus.rdata), 64'(32'h11110002));
        #2 arst = 1'b0;
        #1;
        chk("mid_rst_rvalid", 64'(bus.rvalid), 64'(0));
        chk("mid_rst_ready", 64'({bus.awready, bus.arready}), 64'(0));
        chk("mid_rst_rdata", 64'(bus.rdata), 64'(0));
        chk("mid_rst_ids", 64'({bus.bid, bus.rid}), 64'(0));
        bus.rready = 1'b0;
        model_clear();
        @(negedge aclk);
        arst = 1'b1;
        tick();
        chk("post_rst_awready", 64'(bus.awready), 64'(1));
        chk("post_rst_arready", 64'(bus.arready), 64'(1));
        axi_read(4'd7, 'h40, 1, 2, 1, ok);
        if (ok) begin
            chk("post_rst_rdata0", 64'(rdat[0]), 64'(mword('h40)));
            chk("post_rst_rdata1", 64'(rdat[1]), 64'(0));
            chk("post_rst_rresp", 64'(rrsp[0]), 64'(0));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 cmp_n, bad_n);
        $finish;
    end
endmodule
